axis_pipelined_shifter: RTL and testbench

Pipelined AXI-Stream barrel shifter. It joins a shift-amount stream with a data stream and shifts the data left or right. The data is zero- or sign-extended to the output width first. It sits in the datapath wherever a variable, data-dependent shift must run at full throughput with backpressure.

---
 rtl/axis_shifter_pkg.sv | 33 +++
 rtl/axis_shifter_stage.sv | 78 +++++++
 rtl/axis_pipelined_shifter.sv | 129 ++++++++++++
 tb/tb_axis_pipelined_shifter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined AXI-Stream shifter.
// The stage payload is sized for the widest supported configuration; each
// stage only works on the low DATA_W / SHIFT_W bits and keeps the rest zero.
package axis_shifter_pkg;

  localparam int MAX_DATA_W  = 256;
  localparam int MAX_SHIFT_W = 32;

  // Payload carried by every pipeline register.
  typedef struct packed {
    logic [MAX_DATA_W-1:0]  data;   // partially shifted data
    logic [MAX_SHIFT_W-1:0] shift;  // shift-amount bits not yet resolved
    logic                   last;   // end-of-frame marker
  } stage_payload_t;

  // Number of shift stages needed to resolve shift_w bits, bps bits at a time.
  function automatic int calc_num_stages(input int shift_w, input int bps);
    return (shift_w + bps - 1) / bps;
  endfunction

  // Shift-amount bits resolved by stage k (the last stage may get fewer).
  function automatic int calc_stage_bits(input int shift_w, input int bps, input int k);
    int rem;
    rem = shift_w - k * bps;
    if (rem >= bps) begin
      return bps;
    end else if (rem > 0) begin
      return rem;
    end
    return 0;
  endfunction

endpackage

// File: rtl/axis_shifter_stage.sv
// One registered shift stage. It resolves STAGE_BITS bits of the remaining
// shift amount (weighted by SHIFT_POS) and hands the rest on.
// With STAGE_BITS = 0 it is a plain pipeline register.
//
// Handshake: a beat moves from valid_i into this stage on a rising clock edge
// when valid_i and ready_o are both 1; ready_o is 1 whenever the stage is
// empty or its content is leaving on the same edge (ready_i = 1), so a full
// stage accepts a new beat in the same cycle it hands its own beat on.
module axis_shifter_stage
  import axis_shifter_pkg::*;
#(
  parameter int DATA_W     = 70,
  parameter int STAGE_BITS = 4,
  parameter int SHIFT_POS  = 0,
  parameter bit LEFT       = 1'b1,
  parameter bit ARITH      = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  stage_payload_t pl_i,
  output logic           valid_o,
  input  logic           ready_i,
  output stage_payload_t pl_o
);

  localparam logic [MAX_DATA_W-1:0]  DATA_MASK  = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - DATA_W);
  localparam logic [MAX_SHIFT_W-1:0] FIELD_MASK = ~({MAX_SHIFT_W{1'b1}} << STAGE_BITS);

  logic                   valid_q;
  stage_payload_t         pl_q;
  stage_payload_t         pl_d;
  logic                   load;
  logic [MAX_SHIFT_W-1:0] amt;
  logic [MAX_DATA_W-1:0]  data_in;
  logic [MAX_DATA_W-1:0]  shifted;
  logic                   sign;

  assign load    = ~valid_q | ready_i;
  assign ready_o = load;
  assign valid_o = valid_q;
  assign pl_o    = pl_q;

  // This stage's share of the shift, already weighted by its bit position.
  assign amt = (pl_i.shift & FIELD_MASK) << SHIFT_POS;

  // Shift the payload; right shifts refill from the top with the sign bit
  // when arithmetic, and any overshift collapses to all-fill.
  always_comb begin
    data_in = pl_i.data & DATA_MASK;
    sign    = ARITH ? data_in[DATA_W-1] : 1'b0;
    if (LEFT) begin
      shifted = (data_in << amt) & DATA_MASK;
    end else begin
      shifted = (data_in >> amt) | ({MAX_DATA_W{sign}} & DATA_MASK & ~(DATA_MASK >> amt));
    end
    pl_d       = '0;
    pl_d.data  = shifted;
    pl_d.shift = pl_i.shift >> STAGE_BITS;
    pl_d.last  = pl_i.last;
  end

  // Stage register: valid follows the upstream on every load, data only on
  // real beats so a stalled or drained output keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) begin
        pl_q <= pl_d;
      end
    end
  end

endmodule

// File: rtl/axis_pipelined_shifter.sv
// Pipelined AXI-Stream barrel shifter: joins a shift-amount stream with a
// data stream, extends the data to OUTPUT_WIDTH and shifts it left or right
// over NUM_STAGES registered stages (plus an optional input register).
// Define AXIS_SHIFTER_ASSERT_EN to compile in simulation assertions.
//
// Handshake: every stream transfers on a rising edge where its valid and
// ready are both 1. The two input streams are joined: shift_ready and
// input_ready are the same signal and only rise when both valids are high
// and the pipeline can take a beat, so neither stream is ever consumed alone.
module axis_pipelined_shifter
  import axis_shifter_pkg::*;
#(
  parameter int SHIFT_WIDTH      = 7,
  parameter int INPUT_WIDTH      = 39,
  parameter int OUTPUT_WIDTH     = 70,
  parameter int BITS_PER_STAGE   = 4,
  parameter int LEFT             = 1,
  parameter int ARITHMETIC       = 0,
  parameter int LATCH_INPUT_SYNC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SHIFT_WIDTH-1:0]  shift_data,
  input  logic                    shift_valid,
  output logic                    shift_ready,
  input  logic                    shift_last,
  input  logic [INPUT_WIDTH-1:0]  input_data,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic                    input_last,
  output logic [OUTPUT_WIDTH-1:0] output_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic                    output_last
);

  localparam int NUM_STAGES  = calc_num_stages(SHIFT_WIDTH, BITS_PER_STAGE);
  localparam bit LEFT_B      = (LEFT != 0);
  localparam bit STAGE_ARITH = (ARITHMETIC != 0) && (LEFT == 0);

  stage_payload_t          join_pl;
  logic                    join_valid;
  logic                    join_ready;
  logic [OUTPUT_WIDTH-1:0] ext_data;

  stage_payload_t          pl_c [NUM_STAGES+1];
  logic [NUM_STAGES:0]     vld_c;
  logic [NUM_STAGES:0]     rdy_c;
  logic                    unused_tail;

  assign join_valid  = shift_valid & input_valid;
  // Held low during reset so nothing is acknowledged while the pipe is cleared.
  assign shift_ready = join_valid & join_ready & rst;
  assign input_ready = shift_valid & input_valid & join_ready & rst;

  // Extend the input to the output width and pack the joined beat.
  always_comb begin
    if (ARITHMETIC != 0) begin
      ext_data = OUTPUT_WIDTH'($signed(input_data));
    end else begin
      ext_data = OUTPUT_WIDTH'(input_data);
    end
    join_pl                         = '0;
    join_pl.data[OUTPUT_WIDTH-1:0]  = ext_data;
    join_pl.shift[SHIFT_WIDTH-1:0]  = shift_data;
    join_pl.last                    = shift_last | input_last;
  end

  if (LATCH_INPUT_SYNC != 0) begin : g_sync
    axis_shifter_stage #(
      .DATA_W     (OUTPUT_WIDTH),
      .STAGE_BITS (0),
      .SHIFT_POS  (0),
      .LEFT       (LEFT_B),
      .ARITH      (STAGE_ARITH)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .valid_i (join_valid),
      .ready_o (join_ready),
      .pl_i    (join_pl),
      .valid_o (vld_c[0]),
      .ready_i (rdy_c[0]),
      .pl_o    (pl_c[0])
    );
  end else begin : g_nosync
    assign vld_c[0]   = join_valid;
    assign join_ready = rdy_c[0];
    assign pl_c[0]    = join_pl;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    axis_shifter_stage #(
      .DATA_W     (OUTPUT_WIDTH),
      .STAGE_BITS (calc_stage_bits(SHIFT_WIDTH, BITS_PER_STAGE, k)),
      .SHIFT_POS  (k * BITS_PER_STAGE),
      .LEFT       (LEFT_B),
      .ARITH      (STAGE_ARITH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (vld_c[k]),
      .ready_o (rdy_c[k]),
      .pl_i    (pl_c[k]),
      .valid_o (vld_c[k+1]),
      .ready_i (rdy_c[k+1]),
      .pl_o    (pl_c[k+1])
    );
  end

  assign rdy_c[NUM_STAGES] = output_ready;
  assign output_valid      = vld_c[NUM_STAGES];
  assign output_data       = pl_c[NUM_STAGES].data[OUTPUT_WIDTH-1:0];
  assign output_last       = pl_c[NUM_STAGES].last;
  // Padding bits of the final payload are always zero and not presented.
  assign unused_tail       = ^{pl_c[NUM_STAGES].data, pl_c[NUM_STAGES].shift};

`ifdef AXIS_SHIFTER_ASSERT_EN
  a_width_ok: assert property (@(posedge clk) OUTPUT_WIDTH >= INPUT_WIDTH);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (output_valid && !output_ready) |=>
      (output_valid && $stable(output_data) && $stable(output_last)));

  a_no_x: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown({output_valid, output_data, output_last}));
`endif

endmodule

// File: tb/tb_axis_pipelined_shifter.sv
// Self-checking bench for axis_pipelined_shifter: default (left) instance plus
// an arithmetic-right instance, both checked against a behavioural model.
module tb_axis_pipelined_shifter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // default instance
  logic [6:0]  s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [38:0] i_data = '0;
  logic        i_valid = 1'b0, i_last = 1'b0, i_ready;
  logic [69:0] o_data;
  logic        o_valid, o_last, o_ready = 1'b0;

  // arithmetic right instance
  logic [6:0]  ar_s_data = '0;
  logic        ar_s_valid = 1'b0, ar_s_last = 1'b0, ar_s_ready;
  logic [38:0] ar_i_data = '0;
  logic        ar_i_valid = 1'b0, ar_i_last = 1'b0, ar_i_ready;
  logic [69:0] ar_o_data;
  logic        ar_o_valid, ar_o_last, ar_o_ready = 1'b0;

  logic [70:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  axis_pipelined_shifter u_dut (
    .clk(clk), .rst(rst),
    .shift_data(s_data), .shift_valid(s_valid), .shift_ready(s_ready), .shift_last(s_last),
    .input_data(i_data), .input_valid(i_valid), .input_ready(i_ready), .input_last(i_last),
    .output_data(o_data), .output_valid(o_valid), .output_ready(o_ready), .output_last(o_last)
  );

  axis_pipelined_shifter #(.LEFT(0), .ARITHMETIC(1)) u_ar (
    .clk(clk), .rst(rst),
    .shift_data(ar_s_data), .shift_valid(ar_s_valid), .shift_ready(ar_s_ready), .shift_last(ar_s_last),
    .input_data(ar_i_data), .input_valid(ar_i_valid), .input_ready(ar_i_ready), .input_last(ar_i_last),
    .output_data(ar_o_data), .output_valid(ar_o_valid), .output_ready(ar_o_ready), .output_last(ar_o_last)
  );

  // reference model: {last, result} from the shifting rules
  function automatic logic [70:0] ref_model(input logic [38:0] d, input logic [6:0] s,
                                            input logic l, input bit left, input bit arith);
    logic [69:0] e;
    logic [69:0] r;
    int amt;
    amt = int'(s);
    e = {31'd0, d};
    if (arith && d[38]) e[69:39] = '1;
    if (amt >= 70) r = (!left && arith) ? {70{e[69]}} : '0;
    else if (left) r = e << amt;
    else if (arith) r = 70'($signed(e) >>> amt);
    else r = e >> amt;
    return {l, r};
  endfunction

  // driver: present one beat, wait for the joined handshake, push expectation.
  // Valids stay high on return so consecutive calls run back to back.
  task automatic drive_beat(input logic [6:0] sh, input logic [38:0] d, input logic sl, input logic il);
    int n;
    s_data = sh; i_data = d; s_last = sl; i_last = il;
    s_valid = 1'b1; i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_ready === 1'b1 && i_ready === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drive_handshake: ready=%b/%b after %0d cycles, required 1/1", s_ready, i_ready, n);
    end else begin
      exp_q.push_back(ref_model(d, sh, sl | il, 1'b1, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  // collector: wait (bounded) for one output beat with output_ready held high
  task automatic collect_beat(output logic [70:0] got, output bit ok);
    int n;
    o_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (o_valid === 1'b1);
    got = {o_last, o_data};
    @(posedge clk); #1;
  endtask

  // driver for the arithmetic instance: one beat in, one result out
  task automatic ar_send(input logic [6:0] sh, input logic [38:0] d, input logic l,
                         output logic [70:0] got, output bit ok);
    int n;
    ar_s_data = sh; ar_i_data = d; ar_s_last = l; ar_i_last = 1'b0;
    ar_s_valid = 1'b1; ar_i_valid = 1'b1; ar_o_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (ar_s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (ar_s_ready === 1'b1);
    @(posedge clk); #1;
    ar_s_valid = 1'b0; ar_i_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (ar_o_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = ok && (ar_o_valid === 1'b1);
    got = {ar_o_last, ar_o_data};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 70'd0 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b, required 0/0/0", o_valid, o_data, o_last);
    end
    checks++;
    if (s_ready !== 1'b0 || i_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_readys: %b/%b, required 0/0", s_ready, i_ready);
    end
    checks++;
    if (ar_o_valid !== 1'b0 || ar_o_data !== 70'd0) begin
      errors++;
      $display("FAIL reset_ar: valid=%b data=%h, required 0/0", ar_o_valid, ar_o_data);
    end
    s_valid = 1'b0; i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    o_ready = 1'b1;
    s_data = 7'd3; i_data = 39'd5; s_last = 1'b0; i_last = 1'b0;
    s_valid = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: ready=%b/%b, required 1/1", s_ready, i_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1: output_valid=%b, required 0", o_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency2: output_valid=%b, required 0", o_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 70'd40 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: valid=%b data=%0d last=%b, required 1/40/0", o_valid, o_data, o_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width_edge();
    logic [6:0]  sh_tbl [3];
    logic [69:0] res_tbl [3];
    logic [70:0] got;
    logic [70:0] model;
    bit ok;
    sh_tbl[0] = 7'd31; sh_tbl[1] = 7'd32; sh_tbl[2] = 7'd100;
    res_tbl[0] = 70'd1 << 69; res_tbl[1] = '0; res_tbl[2] = '0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(sh_tbl[i], 39'd1 << 38, 1'b0, 1'b0);
      s_valid = 1'b0; i_valid = 1'b0;
      collect_beat(got, ok);
      model = exp_q.pop_front();
      checks++;
      if (!ok || got[69:0] !== res_tbl[i] || got !== model) begin
        errors++;
        $display("FAIL width_edge shift=%0d: got %h (valid=%b), required %h", sh_tbl[i], got, ok, res_tbl[i]);
      end
    end
  endtask

  task automatic test_join();
    logic [70:0] got;
    logic [70:0] expv;
    bit ok;
    o_ready = 1'b1;
    s_data = 7'd9; s_last = 1'b1; i_last = 1'b0; i_data = 39'h12_3456_789A;
    s_valid = 1'b1; i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || i_ready !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL join_wait cycle %0d: ready=%b/%b out_valid=%b, required 0/0/0", c, s_ready, i_ready, o_valid);
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL join_together: ready=%b/%b, required 1/1", s_ready, i_ready);
    end
    expv = ref_model(39'h12_3456_789A, 7'd9, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0; i_valid = 1'b0; s_last = 1'b0;
    collect_beat(got, ok);
    checks++;
    if (!ok || got !== expv) begin
      errors++;
      $display("FAIL join_result: got %h, required %h", got, expv);
    end
  endtask

  task automatic test_back_to_back();
    int n_beats;
    int start_cyc;
    int drive_cycles;
    int got_n;
    logic [70:0] expv;
    n_beats = 24;
    got_n = 0;
    drive_cycles = 0;
    o_ready = 1'b1;
    fork
      begin
        start_cyc = cyc;
        for (int i = 0; i < n_beats; i++) begin
          drive_beat(7'($urandom_range(0, 127)), 39'({$urandom(), $urandom()}),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drive_cycles = cyc - start_cyc;
        s_valid = 1'b0; i_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && got_n < n_beats; c++) begin
          @(negedge clk);
          if (o_valid === 1'b1 && o_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra: unexpected output %h", o_data);
            end else begin
              expv = exp_q.pop_front();
              if ({o_last, o_data} !== expv) begin
                errors++;
                $display("FAIL b2b_data beat %0d: got %h, required %h", got_n, {o_last, o_data}, expv);
              end
            end
            got_n++;
          end
        end
      end
    join
    checks++;
    if (drive_cycles != n_beats || got_n != n_beats) begin
      errors++;
      $display("FAIL b2b_throughput: %0d beats in %0d cycles, received %0d, required %0d in %0d",
               n_beats, drive_cycles, got_n, n_beats, n_beats);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int got_n;
    bit held_valid;
    bit saw_block;
    logic [70:0] held;
    logic [70:0] expv;
    got_n = 0;
    held_valid = 1'b0;
    saw_block = 1'b0;
    held = '0;
    fork
      begin
        for (int n = 1; n <= 39; n++) begin
          int gap;
          gap = $urandom_range(0, 2);
          s_valid = 1'b0; i_valid = 1'b0;
          repeat (gap) begin
            @(posedge clk); #1;
          end
          drive_beat(7'(n), 39'(n), 1'b0, (n == 39));
        end
        s_valid = 1'b0; i_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && got_n < 39; c++) begin
          @(posedge clk); #1;
          o_ready = ((c % 3) == 0);
          @(negedge clk);
          if (held_valid) begin
            checks++;
            if (o_valid !== 1'b1 || {o_last, o_data} !== held) begin
              errors++;
              $display("FAIL bp_stall_stable: valid=%b out=%h, required 1/%h", o_valid, {o_last, o_data}, held);
            end
          end
          if (s_valid && i_valid && s_ready === 1'b0) saw_block = 1'b1;
          held_valid = (o_valid === 1'b1) && !o_ready;
          held = {o_last, o_data};
          if (o_valid === 1'b1 && o_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL bp_extra: unexpected output %h", o_data);
            end else begin
              expv = exp_q.pop_front();
              if ({o_last, o_data} !== expv) begin
                errors++;
                $display("FAIL bp_data beat %0d: got %h, required %h", got_n + 1, {o_last, o_data}, expv);
              end
            end
            got_n++;
          end
        end
      end
    join
    checks++;
    if (got_n != 39 || exp_q.size() != 0 || !saw_block) begin
      errors++;
      $display("FAIL bp_summary: received %0d left %0d blocked=%b, required 39/0/1", got_n, exp_q.size(), saw_block);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [70:0] got;
    logic [70:0] expv;
    logic [69:0] ones;
    logic [38:0] d;
    logic [6:0]  sh;
    logic        l;
    bit ok;
    ones = '1;
    ar_send(7'd4, 39'h40_0000_0000, 1'b0, got, ok);
    expv = {1'b0, ones};
    expv[33:0] = '0;
    checks++;
    if (!ok || got !== expv) begin
      errors++;
      $display("FAIL arith_shift4: got %h, required %h", got, expv);
    end
    ar_send(7'd127, 39'h40_0000_0000, 1'b1, got, ok);
    checks++;
    if (!ok || got !== {1'b1, ones}) begin
      errors++;
      $display("FAIL arith_shift127: got %h, required %h", got, {1'b1, ones});
    end
    for (int i = 0; i < 10; i++) begin
      d = 39'({$urandom(), $urandom()});
      sh = 7'($urandom_range(0, 80));
      l = 1'($urandom_range(0, 1));
      ar_send(sh, d, l, got, ok);
      expv = ref_model(d, sh, l, 1'b0, 1'b1);
      checks++;
      if (!ok || got !== expv) begin
        errors++;
        $display("FAIL arith_random d=%h s=%0d: got %h, required %h", d, sh, got, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit stale;
    o_ready = 1'b0;
    drive_beat(7'd2, 39'd3, 1'b0, 1'b0);
    drive_beat(7'd5, 39'd1, 1'b0, 1'b1);
    s_valid = 1'b0; i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: output_valid=%b, required 1", o_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 70'd0 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: valid=%b data=%h last=%b, required 0/0/0", o_valid, o_data, o_last);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    o_ready = 1'b1;
    @(posedge clk); #1;
    s_data = 7'd10; i_data = 39'd7; s_last = 1'b0; i_last = 1'b0;
    s_valid = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_handshake: ready=%b/%b, required 1/1", s_ready, i_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    stale = (o_valid !== 1'b0);
    @(posedge clk); @(negedge clk);
    stale = stale || (o_valid !== 1'b0);
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rstmid_early: output_valid=1 before 3 cycles, required 0");
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== (70'd7 << 10)) begin
      errors++;
      $display("FAIL rstmid_first: valid=%b data=%h, required 1/%h", o_valid, o_data, 70'd7 << 10);
    end
    @(posedge clk); #1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rstmid_stale: output_valid seen after drain, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width_edge();
    test_join();
    test_back_to_back();
    test_backpressure();
    test_arith();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
